// File: rtl/xor_64.sv
// Registered 64-bit bitwise XOR unit with zero/sign/overflow flags.
// Datapath is one XOR cell per bit; the zero flag comes from an OR reduction tree.

module xor_64_cell (
  input  logic i_a,
  input  logic i_b,
  output logic o_y_c
);
  assign o_y_c = i_a ^ i_b;
endmodule

// Balanced OR reduction tree, split in halves recursively.
module xor_64_or_tree #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] i_bits,
  output logic             o_any_c
);
  localparam int unsigned LO_W = WIDTH / 2;
  localparam int unsigned HI_W = WIDTH - LO_W;

  generate
    if (WIDTH == 1) begin : g_leaf
      assign o_any_c = i_bits[0];
    end else begin : g_node
      logic w_lo;
      logic w_hi;

      xor_64_or_tree #(.WIDTH(LO_W)) u_lo (
        .i_bits  (i_bits[LO_W-1:0]),
        .o_any_c (w_lo)
      );

      xor_64_or_tree #(.WIDTH(HI_W)) u_hi (
        .i_bits  (i_bits[WIDTH-1:LO_W]),
        .o_any_c (w_hi)
      );

      assign o_any_c = w_lo | w_hi;
    end
  endgenerate
endmodule

module xor_64 #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             zf,
  output logic             sf,
  output logic             of
);
  localparam int unsigned MSB = WIDTH - 1;

  logic [WIDTH-1:0] w_xor;
  logic             w_any;
  logic             w_zf;
  logic             w_sf;

  logic [WIDTH-1:0] r_out;
  logic             r_out_valid;
  logic             r_zf;
  logic             r_sf;
  logic             r_of;

  // One independent XOR cell per bit position.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      xor_64_cell u_cell (
        .i_a   (a[gi]),
        .i_b   (b[gi]),
        .o_y_c (w_xor[gi])
      );
    end
  endgenerate

  xor_64_or_tree #(.WIDTH(WIDTH)) u_zero_tree (
    .i_bits  (w_xor),
    .o_any_c (w_any)
  );

  assign w_zf = ~w_any;
  assign w_sf = w_xor[MSB];

  // Result and flags update only on a qualified capture; reset wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out       <= '0;
      r_zf        <= 1'b1;
      r_sf        <= 1'b0;
      r_of        <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_out <= w_xor;
        r_zf  <= w_zf;
        r_sf  <= w_sf;
        r_of  <= 1'b0;
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign zf        = r_zf;
  assign sf        = r_sf;
  assign of        = r_of;
endmodule

// File: tb/tb_xor_64.sv
// Scoreboard bench for xor_64: stimulus pushes expected results, a negedge monitor pops
// and compares them whenever out_valid is high.

module tb_xor_64;
  logic        clk;
  logic        rst;
  logic [63:0] a;
  logic [63:0] b;
  logic        in_valid;
  logic [63:0] out;
  logic        out_valid;
  logic        zf;
  logic        sf;
  logic        of;

  typedef struct packed {
    logic [63:0] out;
    logic        zf;
    logic        sf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  bit   armed    = 1'b0;

  xor_64 #(.WIDTH(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .out       (out),
    .out_valid (out_valid),
    .zf        (zf),
    .sf        (sf),
    .of        (of)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Monitor: pop one expectation per valid output cycle.
  always @(negedge clk) begin
    if (armed) begin
      chk("of_zero", 64'(of), 64'h0);
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 64'(out_valid), 64'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out", out, e.out);
          chk("zf", 64'(zf), 64'(e.zf));
          chk("sf", 64'(sf), 64'(e.sf));
        end
      end
    end
  end

  // Drive one capture and queue its hand-supplied result.
  task automatic send(input logic [63:0] ta, input logic [63:0] tb_, input logic [63:0] res);
    exp_t e;
    a        = ta;
    b        = tb_;
    in_valid = 1'b1;
    e.out    = res;
    e.zf     = (res == 64'h0);
    e.sf     = res[63];
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [63:0] ta, input logic [63:0] tb_);
    a        = ta;
    b        = tb_;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  logic [63:0] sweep_exp [10] = '{64'd0, 64'd1, 64'd3, 64'd2, 64'd6,
                                  64'd7, 64'd5, 64'd4, 64'd12, 64'd13};

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;
    logic        rv;

    rst      = 1'b1;
    a        = '0;
    b        = '0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", out, 64'h0);
    chk("rst_zf", 64'(zf), 64'h1);
    chk("rst_sf", 64'(sf), 64'h0);
    chk("rst_of", 64'(of), 64'h0);
    chk("rst_valid", 64'(out_valid), 64'h0);
    rst   = 1'b0;
    armed = 1'b1;

    // Counting sweep: a = i, b = i/2.
    for (int i = 0; i < 10; i++) send(64'(i), 64'(i / 2), sweep_exp[i]);

    send(64'hDEADBEEF_CAFEF00D, 64'hDEADBEEF_CAFEF00D, 64'h0);
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);

    for (int k = 0; k < 64; k++) send(64'(1) << k, 64'h0, 64'(1) << k);

    // Hold while idle, then reset beats a simultaneous capture.
    send(64'd5, 64'd3, 64'd6);
    for (int i = 0; i < 3; i++) begin
      idle(64'(i * 17 + 1), 64'(i * 5 + 9));
      chk("hold_out", out, 64'd6);
      chk("hold_valid", 64'(out_valid), 64'h0);
    end
    a        = 64'd7;
    b        = 64'd1;
    in_valid = 1'b1;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    chk("prio_out", out, 64'h0);
    chk("prio_valid", 64'(out_valid), 64'h0);
    chk("prio_zf", 64'(zf), 64'h1);
    rst = 1'b0;

    // Reset one cycle after a capture clears the pending result.
    send(64'd9, 64'd3, 64'd10);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    chk("late_rst_out", out, 64'h0);
    chk("late_rst_valid", 64'(out_valid), 64'h0);
    rst = 1'b0;

    // Random pairs with random qualification.
    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rv = 1'($urandom_range(0, 1));
      if (rv) send(ra, rb, ra ^ rb);
      else    idle(ra, rb);
    end

    idle(64'h0, 64'h0);
    idle(64'h0, 64'h0);
    chk("queue_drained", 64'(exp_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
